xregf_arb: RTL and testbench
============================

XREGF_ARB -- requirements
Module: xregf_arb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the data word width.
REQ-002 SHALL have parameter ADDR_W, default 4, the register-file address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports h_req, h_we (input, 1 bit each): host request and write-enable.
REQ-006 SHALL have ports h_addr (input, ADDR_W) and h_wdata (input, DATA_W): host address and write data.
REQ-007 SHALL have ports h_ack (output, 1 bit) and h_rdata (output, DATA_W): host completion pulse and read data.
REQ-008 SHALL have ports c_req, c_we, c_addr, c_wdata, c_ack, c_rdata, identical to the h_* ports, for the controller data bus.
REQ-009 SHALL have outputs m_en, m_we (1 bit each), m_addr (ADDR_W) and m_wdata (DATA_W), driving the single-port register file.
REQ-010 SHALL have input m_rdata (DATA_W): register-file read data, valid the cycle after m_en.

Function
REQ-011 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, advancing one state per clock.
REQ-012 In IDLE with any req high, SHALL latch the winner's we/addr/wdata, record the winner and enter ISSUE.
REQ-013 In IDLE with no req high, SHALL stay in IDLE.
REQ-014 In ISSUE, SHALL drive m_en=1 and the latched m_we/m_addr/m_wdata from registers; m_en SHALL be 0 in every other state.
REQ-015 In WAIT, SHALL capture m_rdata into the winner's rdata register; a write SHALL leave the winner's rdata unchanged.
REQ-016 In DONE, SHALL drive the winner's ack high for exactly one cycle; the loser's ack SHALL stay 0.
REQ-017 Latency: req first high at rising edge k -> m_en high during cycle k+1 -> ack high during cycle k+3.
REQ-018 Max throughput SHALL be one access per 4 cycles; req SHALL be ignored in ISSUE, WAIT and DONE.
REQ-019 Requesters SHALL hold req/we/addr/wdata until ack; req still high in the cycle after ack SHALL be taken as a new request.
REQ-020 If both req are high in IDLE, SHALL grant round-robin: the requester not granted last wins; a lone request always wins.
REQ-021 The round-robin pointer SHALL update only on a grant.
REQ-022 h_rdata/c_rdata SHALL hold their last captured value until their own next read completes.
REQ-023 The arbiter SHALL never starve a requester: under continuous double requests, grants SHALL alternate H, C, H, C, ...

Reset
REQ-024 rst SHALL act immediately, without waiting for clk, and force: state IDLE; m_en, m_we, h_ack, c_ack = 0; m_addr, m_wdata, h_rdata, c_rdata = 0.
REQ-025 After reset, the round-robin pointer SHALL be set so the first simultaneous conflict grants the host.
REQ-026 Reset asserted mid-access SHALL abort it with no ack; the requester re-arbitrates after reset is released.

Configuration
REQ-027 Macro REGF_ARB_HOSTPRIO_EN defined: fixed priority SHALL apply; the host always wins simultaneous requests; REQ-020, REQ-021 and REQ-023 SHALL be void.
REQ-028 Macro REGF_ARB_HOSTPRIO_EN undefined: round-robin per REQ-020 to REQ-023 SHALL apply; ports and latency SHALL be identical in both builds.

Verification
REQ-029 Host write, h_we=1, h_addr=3, h_wdata=0xDEADBEEF, then host read of addr 3 -> one m_en pulse per access; read gives h_ack at k+3 with h_rdata=0xDEADBEEF.
REQ-030 Both req high continuously, c_addr=5, h_addr=2, from reset -> m_addr sequence 2,5,2,5; acks alternate h,c,h,c, spaced 4 cycles apart.
REQ-031 Same as REQ-030 with REGF_ARB_HOSTPRIO_EN defined -> only h_ack pulses; c_ack stays 0.
REQ-032 Controller read of addr 7 preloaded with 0x12, then host write 0x34 to addr 9 -> c_rdata=0x12 is unchanged after the host's ack.
REQ-033 rst asserted during WAIT of a controller read -> all outputs 0 at once, no c_ack; after release with c_req held, c_ack arrives 3 cycles after the first sampling edge.
REQ-034 Single-cycle h_req glitch arriving during WAIT (dropped before IDLE) -> no grant and no m_en for that glitch.

Source files
------------

// File: rtl/xregf_arb.sv
// rtl/xregf_arb.sv - two-master (host/controller) arbiter for a single-port register file
// Build option: REGF_ARB_HOSTPRIO_EN selects fixed host priority instead of round-robin.
module xregf_arb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_rdata,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_ack,
  output logic [DATA_W-1:0] c_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic                grant_any;
  logic                grant_c;
  logic                win_c;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  assign grant_any = h_req | c_req;

`ifdef REGF_ARB_HOSTPRIO_EN
  assign grant_c = c_req & ~h_req;
`else
  // last_c set means the controller won the previous grant; reset value lets the host win first
  logic last_c;

  assign grant_c = c_req & (~h_req | ~last_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_c <= 1'b1;
    end else if (state == IDLE && grant_any) begin
      last_c <= grant_c;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_en    = (state == ISSUE);
    m_we    = (state == ISSUE) & lat_we;
    m_addr  = lat_addr;
    m_wdata = lat_wdata;
    h_ack   = (state == DONE) & ~win_c;
    c_ack   = (state == DONE) & win_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_c     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      h_rdata   <= '0;
      c_rdata   <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        win_c     <= grant_c;
        lat_we    <= grant_c ? c_we    : h_we;
        lat_addr  <= grant_c ? c_addr  : h_addr;
        lat_wdata <= grant_c ? c_wdata : h_wdata;
      end
      // register file returns read data during WAIT, one cycle after m_en
      if (state == WAIT && !lat_we) begin
        if (win_c) begin
          c_rdata <= m_rdata;
        end else begin
          h_rdata <= m_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_xregf_arb.sv
// tb/tb_xregf_arb.sv - directed self-checking bench for xregf_arb with a behavioural register file
module tb_xregf_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        h_req = 1'b0, h_we = 1'b0;
  logic [3:0]  h_addr = '0;
  logic [31:0] h_wdata = '0;
  logic        h_ack;
  logic [31:0] h_rdata;
  logic        c_req = 1'b0, c_we = 1'b0;
  logic [3:0]  c_addr = '0;
  logic [31:0] c_wdata = '0;
  logic        c_ack;
  logic [31:0] c_rdata;
  logic        m_en, m_we;
  logic [3:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic [31:0] mem [16];
  int          errors = 0;
  int          checks = 0;
  int          en_cnt = 0;
  int          hack_cnt = 0;
  int          cack_cnt = 0;

  xregf_arb #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_ack(h_ack), .h_rdata(h_rdata),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack), .c_rdata(c_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      m_rdata <= mem[m_addr];
      en_cnt  <= en_cnt + 1;
    end
    if (h_ack) hack_cnt <= hack_cnt + 1;
    if (c_ack) cack_cnt <= cack_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_en"}, m_en, 0);
    check({tag, "_m_we"}, m_we, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_wdata"}, m_wdata, 0);
    check({tag, "_h_ack"}, h_ack, 0);
    check({tag, "_c_ack"}, c_ack, 0);
    check({tag, "_h_rdata"}, h_rdata, 0);
    check({tag, "_c_rdata"}, c_rdata, 0);
  endtask

  // one complete access from IDLE: grant at edge k, m_en after k, ack after k+2
  task automatic access(input bit who, input bit we, input logic [3:0] addr, input logic [31:0] wdata,
                        input bit chk_rd, input logic [31:0] exp_rd);
    int en0;
    @(negedge clk);
    if (who) begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wdata; end
    else     begin h_req = 1; h_we = we; h_addr = addr; h_wdata = wdata; end
    en0 = en_cnt;
    @(posedge clk); #1;
    check("acc_m_en", m_en, 1);
    check("acc_m_addr", m_addr, addr);
    check("acc_m_we", m_we, we);
    if (we) check("acc_m_wdata", m_wdata, wdata);
    @(posedge clk); #1;
    check("acc_wait_m_en", m_en, 0);
    @(posedge clk); #1;
    check("acc_ack", who ? c_ack : h_ack, 1);
    check("acc_other_ack", who ? h_ack : c_ack, 0);
    if (chk_rd) check("acc_rdata", who ? c_rdata : h_rdata, exp_rd);
    h_req = 0; c_req = 0;
    @(posedge clk); #1;
    check("acc_ack_end", who ? c_ack : h_ack, 0);
    check("acc_en_pulses", en_cnt - en0, 1);
  endtask

  initial begin
    int base_en, base_h, base_c;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    check("idle_m_en", m_en, 0);

    // host write then read back
    access(0, 1, 4'd3, 32'hDEADBEEF, 0, 0);
    access(0, 0, 4'd3, 32'h0, 1, 32'hDEADBEEF);

    // controller read of preloaded 7, then host write must not disturb c_rdata
    access(1, 1, 4'd7, 32'h12, 0, 0);
    access(1, 0, 4'd7, 32'h0, 1, 32'h12);
    access(0, 1, 4'd9, 32'h34, 0, 0);
    check("c_rdata_hold", c_rdata, 32'h12);
    check("h_rdata_hold", h_rdata, 32'hDEADBEEF);

    // one-cycle host glitch during WAIT of a controller read is ignored
    base_en = en_cnt; base_h = hack_cnt;
    @(negedge clk); c_req = 1; c_we = 0; c_addr = 4'd7;
    @(posedge clk); @(posedge clk);
    @(negedge clk); h_req = 1; h_we = 1; h_addr = 4'd1;
    @(negedge clk); h_req = 0; c_req = 0;
    repeat (6) @(posedge clk);
    #1;
    check("glitch_en_cnt", en_cnt - base_en, 1);
    check("glitch_no_h_ack", hack_cnt - base_h, 0);
    check("glitch_c_rdata", c_rdata, 32'h12);

    // continuous double requests from reset
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    h_req = 1; h_we = 1; h_addr = 4'd2; h_wdata = 32'hA;
    c_req = 1; c_we = 1; c_addr = 4'd5; c_wdata = 32'hB;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      check($sformatf("dbl_m_en_%0d", i), m_en, (i % 4) == 0);
`ifdef REGF_ARB_HOSTPRIO_EN
      check($sformatf("dbl_h_ack_%0d", i), h_ack, (i % 4) == 2);
      check($sformatf("dbl_c_ack_%0d", i), c_ack, 0);
      if (i % 4 == 0) check($sformatf("dbl_m_addr_%0d", i), m_addr, 2);
`else
      check($sformatf("dbl_h_ack_%0d", i), h_ack, (i % 8) == 2);
      check($sformatf("dbl_c_ack_%0d", i), c_ack, (i % 8) == 6);
      if (i % 4 == 0) check($sformatf("dbl_m_addr_%0d", i), m_addr, (i % 8) == 0 ? 2 : 5);
`endif
    end
    @(negedge clk); h_req = 0; c_req = 0;
    repeat (2) @(posedge clk);

    // reset during WAIT of a controller read: immediate clear, no ack, then retry
    access(1, 0, 4'd7, 32'h0, 1, 32'h12);
    @(negedge clk); c_req = 1; c_we = 0; c_addr = 4'd7;
    @(posedge clk); @(posedge clk);
    #2 rst = 1;
    #1 check_all_zero("rst_async");
    base_c = cack_cnt;
    @(negedge clk); rst = 0;
    check("rst_no_c_ack", cack_cnt - base_c, 0);
    @(posedge clk); #1;
    check("retry_m_en", m_en, 1);
    @(posedge clk); #1;
    check("retry_wait_ack", c_ack, 0);
    @(posedge clk); #1;
    check("retry_c_ack", c_ack, 1);
    check("retry_c_rdata", c_rdata, 32'h12);
    c_req = 0;
    @(posedge clk);

    // pointer moves only on grants: two lone host grants, then a conflict
    access(0, 1, 4'd1, 32'h1, 0, 0);
    access(0, 1, 4'd1, 32'h2, 0, 0);
    @(negedge clk);
    h_req = 1; h_we = 1; h_addr = 4'd2;
    c_req = 1; c_we = 1; c_addr = 4'd5;
    @(posedge clk); #1;
`ifdef REGF_ARB_HOSTPRIO_EN
    check("rr_after_host_addr", m_addr, 2);
`else
    check("rr_after_host_addr", m_addr, 5);
`endif
    h_req = 0; c_req = 0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
